// File: rtl/consol_arbiter_pkg.sv
// Shared constants and types for the round-robin consolidation arbiter.
// One byte is four 2-bit beats; missing beats are filled with PAD_BEAT.
package consol_pkg;
  localparam int         BEATS_PER_BYTE = 4;
  localparam logic [1:0] BEAT_LAST      = 2'(BEATS_PER_BYTE - 1);
  localparam logic [1:0] PAD_BEAT       = 2'b00;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;
endpackage

// File: rtl/consol_arbiter_rr_pick.sv
// Combinational circular priority encoder: first set request at or above
// i_ptr, wrapping at NUM_SRC.
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [SRC_W-1:0]   i_ptr,
  output logic               o_valid,
  output logic [SRC_W-1:0]   o_id
);
  logic [2*NUM_SRC-1:0] w_dbl;
  logic [NUM_SRC-1:0]   w_rot;
  logic [SRC_W:0]       w_sum;

  // Rotating a doubled copy puts the ptr slot at bit 0.
  assign w_dbl = {i_req, i_req};
  assign w_rot = NUM_SRC'(w_dbl >> i_ptr);

  always_comb begin
    o_valid = 1'b0;
    o_id    = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!o_valid && w_rot[k]) begin
        o_valid = 1'b1;
        w_sum   = {1'b0, i_ptr} + (SRC_W+1)'(k);
        if (w_sum >= (SRC_W+1)'(NUM_SRC)) w_sum = w_sum - (SRC_W+1)'(NUM_SRC);
        o_id    = w_sum[SRC_W-1:0];
      end
    end
  end
endmodule

// File: rtl/consol_arbiter.sv
// Round-robin scheduler feeding one 2-bit to 8-bit packer; each grant is held
// for exactly one byte (four contiguous beats) and bytes are tagged by source.
module consol_arbiter
  import consol_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 arb_en,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [2*NUM_SRC-1:0] src_din,
  output logic [NUM_SRC-1:0]   src_ack,
  output logic [1:0]           pk_din,
  output logic                 pk_din_en,
  output logic [SRC_W-1:0]     byte_src,
  output logic                 pad_err,
  output logic                 busy
);
  state_t             r_state, w_state_next;
  logic [SRC_W-1:0]   r_gnt, w_gnt_next;
  logic [SRC_W-1:0]   r_ptr, w_ptr_next;
  logic [1:0]         r_beat, w_beat_next;
  logic [SRC_W-1:0]   r_pk_src;
  logic               r_pk_last;
  logic [SRC_W-1:0]   w_ptr_inc, w_pick_ptr, w_pick_id;
  logic               w_pick_valid, w_gnt_req, w_byte_end;
  logic [NUM_SRC-1:0] w_pick_req;
  logic [1:0]         w_beats [NUM_SRC];

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slice
      assign w_beats[gi] = src_din[2*gi +: 2];
    end
  endgenerate

  assign busy       = (r_state == XFER);
  assign w_gnt_req  = busy && src_req[r_gnt];
  assign w_byte_end = busy && (r_beat == BEAT_LAST);
  assign w_ptr_inc  = (r_gnt == SRC_W'(NUM_SRC - 1)) ? '0 : r_gnt + 1'b1;
  // At a byte boundary the search already starts past the current grant,
  // and the beat being consumed right now must not count as a new request.
  assign w_pick_ptr = busy ? w_ptr_inc : r_ptr;
  assign w_pick_req = src_req & ~src_ack;

  always_comb begin
    src_ack = '0;
    if (w_gnt_req) src_ack[r_gnt] = 1'b1;
  end

  rr_pick #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_pick (
    .i_req  (w_pick_req),
    .i_ptr  (w_pick_ptr),
    .o_valid(w_pick_valid),
    .o_id   (w_pick_id)
  );

  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_ptr_next   = r_ptr;
    w_beat_next  = r_beat;
    case (r_state)
      IDLE: begin
        if (arb_en && w_pick_valid) begin
          w_state_next = XFER;
          w_gnt_next   = w_pick_id;
          w_beat_next  = '0;
        end
      end
      XFER: begin
        w_beat_next = r_beat + 1'b1;
        if (w_byte_end) begin
          w_ptr_next = w_ptr_inc;
          if (arb_en && w_pick_valid) begin
            w_gnt_next  = w_pick_id;
            w_beat_next = '0;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_ptr   <= w_ptr_next;
      r_beat  <= w_beat_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pk_din    <= '0;
      pk_din_en <= 1'b0;
      pad_err   <= 1'b0;
      r_pk_src  <= '0;
      r_pk_last <= 1'b0;
      byte_src  <= '0;
    end else begin
      pk_din    <= w_gnt_req ? w_beats[r_gnt] : PAD_BEAT;
      pk_din_en <= busy;
      pad_err   <= busy && !w_gnt_req;
      r_pk_src  <= r_gnt;
      r_pk_last <= w_byte_end;
      if (pk_din_en && r_pk_last) byte_src <= r_pk_src;
    end
  end
endmodule

// File: tb/tb_consol_arbiter.sv
// Bench for consol_arbiter: directed scenarios plus random round-robin traffic,
// checked against a byte-level round-robin model and a packer model.
module tb_consol_arbiter;
  localparam int NS = 4;

  logic          clk, rstn;
  logic          arb_en;
  logic [NS-1:0] src_req, src_ack;
  logic [2*NS-1:0] src_din;
  logic [1:0]    pk_din, byte_src;
  logic          pk_din_en, pad_err, busy;

  logic          arb3;
  logic [2:0]    src_req3, src_ack3;
  logic [5:0]    src_din3;
  logic [1:0]    pk_din3, byte_src3;
  logic          pk_din_en3, pad_err3, busy3;

  consol_arbiter #(.NUM_SRC(NS)) dut (
    .clk(clk), .rstn(rstn), .arb_en(arb_en), .src_req(src_req), .src_din(src_din),
    .src_ack(src_ack), .pk_din(pk_din), .pk_din_en(pk_din_en), .byte_src(byte_src),
    .pad_err(pad_err), .busy(busy));

  consol_arbiter #(.NUM_SRC(3)) dut3 (
    .clk(clk), .rstn(rstn), .arb_en(arb3), .src_req(src_req3), .src_din(src_din3),
    .src_ack(src_ack3), .pk_din(pk_din3), .pk_din_en(pk_din_en3), .byte_src(byte_src3),
    .pad_err(pad_err3), .busy(busy3));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [1:0] src_q   [NS][$];
  logic [7:0] m_bytes [NS][$];
  int         m_ptr = 0;
  logic [7:0] exp_byte[$];
  int         exp_src [$];
  logic [7:0] got_byte[$];
  int         got_src [$];
  int         got_cyc [$];
  int         ack_cnt [NS];
  int         g3[$];
  int         ack3_n = 0;
  int         max_ptr3 = 0;

  int         pk_cnt = 0, run = 0, max_run = 0, pads = 0, first_en = -1;
  logic [7:0] pk_sh = '0;
  bit         tag_pend = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Packer model: four contiguous beats form a byte, first beat in the MSBs;
  // the tag is sampled one cycle later, alongside the packer's dout_en.
  always @(negedge clk) begin
    if (!rstn) begin
      pk_cnt   = 0;
      run      = 0;
      tag_pend = 0;
    end else begin
      if (tag_pend) begin
        got_src.push_back(int'(byte_src));
        got_cyc.push_back(cyc);
        tag_pend = 0;
      end
      if (pk_din_en) begin
        pk_sh = {pk_sh[5:0], pk_din};
        if (first_en < 0) first_en = cyc;
        run++;
        if (run > max_run) max_run = run;
        if (pk_cnt == 3) begin
          got_byte.push_back(pk_sh);
          pk_cnt   = 0;
          tag_pend = 1;
        end else begin
          pk_cnt++;
        end
      end else begin
        pk_cnt = 0;
        run    = 0;
      end
      if (pad_err) pads++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void drive_srcs();
    for (int i = 0; i < NS; i++) begin
      src_req[i]       = (src_q[i].size() > 0);
      src_din[2*i +: 2] = (src_q[i].size() > 0) ? src_q[i][0] : 2'b00;
    end
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < NS; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void load_byte(input int s, input logic [7:0] b);
    src_q[s].push_back(b[7:6]);
    src_q[s].push_back(b[5:4]);
    src_q[s].push_back(b[3:2]);
    src_q[s].push_back(b[1:0]);
    m_bytes[s].push_back(b);
  endfunction

  // Round-robin at byte granularity: next byte comes from the first source
  // at or after ptr that still has a whole byte; ptr then moves past it.
  function automatic void predict();
    int  p = m_ptr;
    bit  found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int k = 0; k < NS && !found; k++) begin
        int s = (p + k) % NS;
        if (m_bytes[s].size() > 0) begin
          exp_byte.push_back(m_bytes[s].pop_front());
          exp_src.push_back(s);
          p = (s + 1) % NS;
          found = 1'b1;
        end
      end
    end
    m_ptr = p;
  endfunction

  task automatic step();
    logic [NS-1:0] a;
    logic [2:0]    a3;
    @(negedge clk);
    a  = src_ack;
    a3 = src_ack3;
    for (int i = 0; i < NS; i++) if (a[i]) ack_cnt[i]++;
    if (a3 != 3'b000) begin
      if (ack3_n % 4 == 0)
        for (int i = 0; i < 3; i++) if (a3[i]) g3.push_back(i);
      ack3_n++;
    end
    if (int'(dut3.r_ptr) > max_ptr3) max_ptr3 = int'(dut3.r_ptr);
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++)
      if (a[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive_srcs();
  endtask

  task automatic clear_stats();
    for (int i = 0; i < NS; i++) ack_cnt[i] = 0;
    pads = 0;
    max_run = 0;
    first_en = -1;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while ((busy || any_pending() || got_src.size() < exp_src.size()) && n < budget) begin
      step();
      n++;
    end
    check({tag, " done in budget"}, (n < budget) ? 1 : 0, 1);
    repeat (2) step();
  endtask

  task automatic step_until_ack(input string tag, input int s, input int n);
    int k = 0;
    while (ack_cnt[s] < n && k < 50) begin
      step();
      k++;
    end
    check(tag, ack_cnt[s], n);
  endtask

  task automatic compare_bytes(input string tag);
    check({tag, " byte count"}, got_byte.size(), exp_byte.size());
    check({tag, " tag count"}, got_src.size(), exp_src.size());
    for (int k = 0; k < exp_byte.size() && k < got_byte.size(); k++)
      check($sformatf("%s byte%0d", tag, k), got_byte[k], exp_byte[k]);
    for (int k = 0; k < exp_src.size() && k < got_src.size(); k++)
      check($sformatf("%s src%0d", tag, k), got_src[k], exp_src[k]);
    exp_byte.delete();
    exp_src.delete();
    got_byte.delete();
    got_src.delete();
    got_cyc.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int exp3 [4];
    rstn = 1'b0;
    arb_en = 1'b1;
    src_req = '0;
    src_din = '0;
    arb3 = 1'b0;
    src_req3 = '0;
    src_din3 = '0;
    exp3 = '{0, 1, 2, 0};
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("reset pk_din_en", pk_din_en, 0);
    check("reset pk_din", pk_din, 0);
    check("reset pad_err", pad_err, 0);
    check("reset byte_src", byte_src, 0);
    check("reset busy", busy, 0);
    check("reset src_ack", src_ack, 0);
    rstn = 1'b1;
    step();

    // Sources 0,1,3 with one byte each: served 0,1,3 back to back.
    clear_stats();
    load_byte(0, 8'($urandom));
    load_byte(1, 8'($urandom));
    load_byte(3, 8'($urandom));
    predict();
    drive_srcs();
    run_until_done("t2", 100);
    check("t2 contiguous beats", max_run, 12);
    check("t2 ptr end", dut.r_ptr, 0);
    compare_bytes("t2");

    // Single source 2, byte 8'hC9, latency from request to tag.
    clear_stats();
    load_byte(2, 8'hC9);
    predict();
    drive_srcs();
    t0 = cyc;
    run_until_done("t1", 100);
    check("t1 acks src2", ack_cnt[2], 4);
    check("t1 acks others", ack_cnt[0] + ack_cnt[1] + ack_cnt[3], 0);
    check("t1 pad_err count", pads, 0);
    check("t1 first din_en cycle", first_en, t0 + 2);
    check("t1 tag cycle", (got_cyc.size() > 0) ? got_cyc[0] : -1, t0 + 6);
    compare_bytes("t1");

    // Source 1 supplies only two beats: two pads complete the byte.
    clear_stats();
    src_q[1].push_back(2'b01);
    src_q[1].push_back(2'b10);
    exp_byte.push_back(8'h60);
    exp_src.push_back(1);
    m_ptr = 2;
    drive_srcs();
    run_until_done("t3", 100);
    check("t3 acks src1", ack_cnt[1], 2);
    check("t3 pad_err count", pads, 2);
    compare_bytes("t3");

    // arb_en dropped during beat 1 of source 0: byte completes, nothing new.
    clear_stats();
    load_byte(0, 8'($urandom));
    predict();
    drive_srcs();
    step_until_ack("t4 beat0 acked", 0, 1);
    arb_en = 1'b0;
    load_byte(1, 8'($urandom));
    load_byte(2, 8'($urandom));
    drive_srcs();
    repeat (8) step();
    check("t4 src0 acks", ack_cnt[0], 4);
    check("t4 src1 acks while disabled", ack_cnt[1], 0);
    check("t4 src2 acks while disabled", ack_cnt[2], 0);
    check("t4 busy while disabled", busy, 0);
    check("t4 bytes while disabled", got_byte.size(), 1);
    arb_en = 1'b1;
    predict();
    run_until_done("t4", 100);
    compare_bytes("t4");

    // Reset during beat 2: outputs clear at once and the partial byte is lost.
    clear_stats();
    load_byte(2, 8'($urandom));
    m_bytes[2].delete();
    drive_srcs();
    step_until_ack("t5 beats acked", 2, 2);
    rstn = 1'b0;
    #1;
    check("t5 async pk_din_en", pk_din_en, 0);
    check("t5 async pk_din", pk_din, 0);
    check("t5 async pad_err", pad_err, 0);
    check("t5 async byte_src", byte_src, 0);
    check("t5 async busy", busy, 0);
    check("t5 async src_ack", src_ack, 0);
    for (int i = 0; i < NS; i++) src_q[i].delete();
    drive_srcs();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    m_ptr = 0;
    repeat (3) step();
    check("t5 partial byte dropped", got_byte.size(), 0);
    load_byte(3, 8'($urandom));
    load_byte(1, 8'($urandom));
    predict();
    drive_srcs();
    run_until_done("t5", 100);
    compare_bytes("t5");

    // Random whole-byte traffic against the round-robin model.
    for (int r = 0; r < 4; r++) begin
      clear_stats();
      for (int i = 0; i < NS; i++) begin
        int nb = $urandom_range(3, 0);
        for (int b = 0; b < nb; b++) load_byte(i, 8'($urandom));
      end
      predict();
      drive_srcs();
      run_until_done($sformatf("rand%0d", r), 400);
      check($sformatf("rand%0d pads", r), pads, 0);
      compare_bytes($sformatf("rand%0d", r));
    end

    // Three sources, all requesting continuously: grants 0,1,2,0.
    src_din3 = 6'($urandom);
    src_req3 = 3'b111;
    arb3 = 1'b1;
    repeat (18) step();
    arb3 = 1'b0;
    src_req3 = '0;
    repeat (6) step();
    check("t6 grant count", (g3.size() >= 4) ? 1 : 0, 1);
    for (int k = 0; k < 4 && k < g3.size(); k++)
      check($sformatf("t6 grant%0d", k), g3[k], exp3[k]);
    check("t6 max ptr", max_ptr3, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
